// File: rtl/aes_key_expand_iter_pkg.sv
// aes_key_expand_iter_pkg: shared AES constants, FSM encoding and the xtime helper.
package aes_key_expand_iter_pkg;
    localparam logic [3:0] AES_NR    = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [0:0] state_t;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_key_expand_iter_if.sv
// aes_key_expand_iter_if: start/key request and round-key stream between key schedule and consumer.
interface aes_key_expand_iter_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_round, rk_out, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_round, rk_out, done
    );
endinterface

// File: rtl/aes_key_expand_iter_sbox.sv
// aes_key_expand_iter_sbox: combinational AES forward S-box, also reused by the cipher's SubBytes.
module aes_key_expand_iter_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX[a_i];
endmodule

// File: rtl/aes_key_expand_iter.sv
// aes_key_expand_iter: iterative AES-128 key schedule streaming round keys 0..10 over a valid/ready handshake.
module aes_key_expand_iter
    import aes_key_expand_iter_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_key_expand_iter_if.slave bus
);
    if (NR != int'(AES_NR) || KEY_W != 128) begin : g_bad_param
        $error("aes_key_expand_iter supports only NR=10 and KEY_W=128");
    end

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_d, rk_nxt;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;
    logic [31:0]  rot_w, sub_w, t_w, n0, n1, n2, n3;
    logic         run, accept, hs;

    assign rot_w = {rk_q[23:0], rk_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_key_expand_iter_sbox u_sbox (
            .a_i (rot_w[8*g +: 8]),
            .s_o (sub_w[8*g +: 8])
        );
    end

    // Next round key is derived from the registered key, so the S-box starts the path.
    assign t_w    = sub_w ^ {rcon_q, 24'h0};
    assign n0     = rk_q[127:96] ^ t_w;
    assign n1     = rk_q[95:64]  ^ n0;
    assign n2     = rk_q[63:32]  ^ n1;
    assign n3     = rk_q[31:0]   ^ n2;
    assign rk_nxt = {n0, n1, n2, n3};

    assign run    = state_q == RUN;
    assign accept = !run && bus.start;
    assign hs     = run && bus.rk_ready;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = RUN;
            rk_d    = bus.key_in;
            round_d = 4'd0;
            rcon_d  = RCON_INIT;
        end else if (hs && round_q == AES_NR) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else if (hs) begin
            rk_d    = rk_nxt;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = run;
    assign bus.rk_valid = run;
    assign bus.rk_round = round_q;
    assign bus.rk_out   = rk_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_key_expand_iter.sv
// tb_aes_key_expand_iter: randomized handshake bench against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expand_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_iter_if bus();

    aes_key_expand_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [7:0]   sb [256];
    logic [127:0] sched [11];
    bit           act = 0;
    bit           fresh = 1;
    bit           done_e = 0;
    int           idx = 0;
    int           hs_cnt = 0;
    int           dut_done_cnt = 0;
    logic [127:0] hs_log [$];
    logic [127:0] t1_log [$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endfunction

    function automatic void expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            act = 0; idx = 0; fresh = 1; done_e = 0;
        end else begin
            done_e = 0;
            if (act && bus.rk_ready) begin
                hs_cnt++;
                hs_log.push_back(bus.rk_out);
                if (idx == 10) begin
                    act = 0; done_e = 1;
                end else idx++;
            end else if (!act && bus.start) begin
                expand_key(bus.key_in);
                act = 1; idx = 0; fresh = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 128'(bus.busy), 128'(act));
        chk("rk_valid", 128'(bus.rk_valid), 128'(act));
        chk("done", 128'(bus.done), 128'(done_e));
        if (act || fresh) begin
            chk("rk_round", 128'(bus.rk_round), act ? 128'(idx) : 128'(0));
            chk("rk_out", bus.rk_out, act ? sched[idx] : 128'(0));
        end
        if (bus.done === 1'b1) dut_done_cnt++;
    end

    task automatic run(input logic [127:0] k, input int mode, output int lat);
        int stall = 0;
        bit injected = 0;
        hs_log.delete();
        hs_cnt = 0;
        lat = -1;
        bus.start = 1'b1; bus.key_in = k; bus.rk_ready = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk); #1;
            bus.start = 1'b0;
            bus.key_in = {$urandom, $urandom, $urandom, $urandom};
            if (rst_n == 1'b0) begin
                chk("rst_busy", 128'(bus.busy), 128'(0));
                chk("rst_valid", 128'(bus.rk_valid), 128'(0));
                chk("rst_done", 128'(bus.done), 128'(0));
                chk("rst_round", 128'(bus.rk_round), 128'(0));
                chk("rst_out", bus.rk_out, 128'(0));
                rst_n = 1'b1;
                lat = n;
                return;
            end
            if (bus.done) begin
                lat = n;
                return;
            end
            if (mode == 3 && bus.rk_valid && bus.rk_round == 4'd6) rst_n = 1'b0;
            if (mode == 2 && bus.rk_round == 4'd4 && !injected) begin
                bus.start = 1'b1; injected = 1;
            end
            if (mode == 1) begin
                if (bus.rk_valid && bus.rk_round == 4'd5 && stall < 3) begin
                    bus.rk_ready = 1'b0; stall++;
                end else bus.rk_ready = 1'($urandom_range(0, 1));
            end else bus.rk_ready = 1'b1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL run_timeout: mode %0d got no done within 200 cycles, required done", mode);
    endtask

    initial begin
        int lat, first, second;
        bus.start = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0;
        build_sbox();
        chk("model_sbox_00", 128'(sb[0]), 128'(8'h63));
        chk("model_sbox_53", 128'(sb[8'h53]), 128'(8'hed));
        expand_key(K1);
        chk("model_t1_r1", sched[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_t1_r2", sched[2], 128'hf2c295f27a96b9435935807a7359f67f);
        chk("model_t1_r10", sched[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand_key(128'h0);
        chk("model_t3_r1", sched[1], 128'h62636363626363636263636362636363);
        chk("model_t3_r10", sched[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        run(K1, 0, lat);
        chk("t1_done_latency", 128'(lat), 128'(12));
        chk("t1_handshakes", 128'(hs_cnt), 128'(11));
        chk("t1_r0", hs_log[0], K1);
        chk("t1_r1", hs_log[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("t1_r2", hs_log[2], 128'hf2c295f27a96b9435935807a7359f67f);
        chk("t1_r10", hs_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        t1_log = hs_log;

        run(K1, 1, lat);
        chk("t2_handshakes", 128'(hs_cnt), 128'(11));
        for (int i = 0; i < 11; i++) chk($sformatf("t2_key%0d", i), hs_log[i], t1_log[i]);

        run(128'h0, 0, lat);
        chk("t3_r1", hs_log[1], 128'h62636363626363636263636362636363);
        chk("t3_r10", hs_log[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run(K1, 2, lat);
        chk("t4_handshakes", 128'(hs_cnt), 128'(11));
        for (int i = 0; i < 11; i++) chk($sformatf("t4_key%0d", i), hs_log[i], t1_log[i]);

        run(K1, 3, lat);
        run(K1, 0, lat);
        chk("t5_restart_latency", 128'(lat), 128'(12));
        chk("t5_restart_r0", hs_log[0], K1);

        hs_cnt = 0;
        first = -1; second = -1;
        lat = dut_done_cnt;
        bus.start = 1'b1; bus.key_in = K1; bus.rk_ready = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk); #1;
            if (first > 0 && n == first + 1)
                chk("t6_second_r0", 128'({bus.rk_valid, bus.rk_round}), 128'({1'b1, 4'd0}));
            if (bus.done) begin
                if (first < 0) first = n;
                else begin
                    second = n; bus.start = 1'b0; break;
                end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        chk("t6_first_done", 128'(first), 128'(12));
        chk("t6_second_done", 128'(second), 128'(24));
        chk("t6_done_count", 128'(dut_done_cnt - lat), 128'(2));
        chk("t6_handshakes", 128'(hs_cnt), 128'(22));
        chk("t6_idle", 128'(bus.busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
